// File: rtl/adc_serial_rx_mc.sv
// Multi-channel MSB-first serial ADC frame receiver: shared CS, parallel capture, valid/ready output.
// Optional macro ADC_LEAD_CHECK_EN enables the sticky leading-bit error flag on err_o.
module adc_serial_rx_mc #(
  parameter int CHANNELS   = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int GAP_CYCLES = 2
) (
  input  logic                                     clk_adc,
  input  logic                                     rst_adc,
  input  logic                                     start_i,
  input  logic                                     cont_i,
  input  logic [CHANNELS-1:0]                      data_i,
  input  logic                                     ready_i,
  input  logic                                     clr_i,
  output logic                                     cs_o,
  output logic [CHANNELS*DATA_BITS-1:0]            data_o,
  output logic [CHANNELS*(FRAME_BITS-DATA_BITS)-1:0] lead_o,
  output logic                                     valid_o,
  output logic                                     overrun_o,
  output logic                                     err_o,
  output logic                                     busy_o
);

  localparam int LEAD_BITS = FRAME_BITS - DATA_BITS;
  localparam int CW = $clog2(FRAME_BITS);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic [CW-1:0]                         r_bit_cnt;
  logic [GW-1:0]                         r_gap_cnt;
  logic [CHANNELS-1:0][FRAME_BITS-2:0]   r_shift;
  logic [CHANNELS-1:0][FRAME_BITS-1:0]   w_frame;
  logic [CHANNELS*DATA_BITS-1:0]         w_data_nxt;
  logic [CHANNELS*LEAD_BITS-1:0]         w_lead_nxt;
  logic                                  r_cs;
  logic                                  r_valid;
  logic                                  r_ovr;
  logic [CHANNELS*DATA_BITS-1:0]         r_data;
  logic [CHANNELS*LEAD_BITS-1:0]         r_lead;
  logic                                  w_done;
  logic                                  w_gap_end;
  logic                                  w_ovr_set;

  assign w_done    = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);
  assign w_gap_end = (r_state == ST_GAP) && (r_gap_cnt == LAST_GAP);
  assign w_ovr_set = w_done && r_valid && !ready_i;

  // State register
  always_ff @(posedge clk_adc or posedge rst_adc) begin
    if (rst_adc) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = (start_i || cont_i) ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_state_nxt = w_done ? ST_GAP : ST_SHIFT;
      ST_GAP:   w_state_nxt = w_gap_end ? ST_IDLE : ST_GAP;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Complete frame as it would look after this edge's shift, split into sample and lead fields
  always_comb begin
    w_frame    = '0;
    w_data_nxt = '0;
    w_lead_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_frame[c] = {r_shift[c], data_i[c]};
      w_data_nxt[c*DATA_BITS +: DATA_BITS] = w_frame[c][DATA_BITS-1:0];
      w_lead_nxt[c*LEAD_BITS +: LEAD_BITS] = w_frame[c][FRAME_BITS-1:DATA_BITS];
    end
  end

  // Shift registers, bit/gap counters and chip-select
  always_ff @(posedge clk_adc or posedge rst_adc) begin
    if (rst_adc) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_cs      <= 1'b1;
    end else begin
      // CS follows the state being entered, so it is low exactly while in SHIFT
      r_cs <= (w_state_nxt != ST_SHIFT);
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_gap_cnt <= '0;
        end
        ST_SHIFT: begin
          for (int c = 0; c < CHANNELS; c++) begin
            r_shift[c] <= w_frame[c][FRAME_BITS-2:0];
          end
          r_bit_cnt <= w_done ? '0 : r_bit_cnt + CW'(1);
          r_gap_cnt <= '0;
        end
        ST_GAP: begin
          r_gap_cnt <= r_gap_cnt + GW'(1);
        end
        default: begin
          r_bit_cnt <= '0;
          r_gap_cnt <= '0;
        end
      endcase
    end
  end

  // Output sample registers, handshake and sticky overrun
  always_ff @(posedge clk_adc or posedge rst_adc) begin
    if (rst_adc) begin
      r_data  <= '0;
      r_lead  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_done) begin
        r_data  <= w_data_nxt;
        r_lead  <= w_lead_nxt;
        r_valid <= 1'b1;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (clr_i) begin
        r_ovr <= 1'b0;
      end else begin
        r_ovr <= r_ovr;
      end
    end
  end

`ifdef ADC_LEAD_CHECK_EN
  logic r_err;

  // Sticky error when any channel's leading bits are non-zero at frame completion
  always_ff @(posedge clk_adc or posedge rst_adc) begin
    if (rst_adc) begin
      r_err <= 1'b0;
    end else if (w_done && (|w_lead_nxt)) begin
      r_err <= 1'b1;
    end else if (clr_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign cs_o      = r_cs;
  assign data_o    = r_data;
  assign lead_o    = r_lead;
  assign valid_o   = r_valid;
  assign overrun_o = r_ovr;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adc_serial_rx_mc.sv
// Self-checking bench for adc_serial_rx_mc: timeline reference model, per-cycle compare, directed plus random stimulus.
module tb_adc_serial_rx_mc;

  localparam int CH = 2;
  localparam int FB = 16;
  localparam int DB = 12;
  localparam int GC = 2;
  localparam int LB = FB - DB;

  logic              clk_adc = 1'b0;
  logic              rst_adc = 1'b1;
  logic              start_i = 1'b0;
  logic              cont_i  = 1'b0;
  logic [CH-1:0]     data_i  = '0;
  logic              ready_i = 1'b0;
  logic              clr_i   = 1'b0;
  logic              cs_o;
  logic [CH*DB-1:0]  data_o;
  logic [CH*LB-1:0]  lead_o;
  logic              valid_o;
  logic              overrun_o;
  logic              err_o;
  logic              busy_o;

  adc_serial_rx_mc #(.CHANNELS(CH), .FRAME_BITS(FB), .DATA_BITS(DB), .GAP_CYCLES(GC)) dut (
    .clk_adc(clk_adc), .rst_adc(rst_adc), .start_i(start_i), .cont_i(cont_i),
    .data_i(data_i), .ready_i(ready_i), .clr_i(clr_i), .cs_o(cs_o),
    .data_o(data_o), .lead_o(lead_o), .valid_o(valid_o), .overrun_o(overrun_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  initial forever #5 clk_adc = ~clk_adc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline of edges counted from the start edge.
  bit               m_active = 1'b0;
  int               m_k = 0;
  logic [FB-1:0]    m_word [CH];
  logic [FB-1:0]    m_acc  [CH];
  logic [FB-1:0]    fixed_word [CH];
  bit               use_fixed = 1'b0;
  bit               m_cs = 1'b1;
  bit               m_valid = 1'b0;
  bit               m_ovr = 1'b0;
  bit               m_err = 1'b0;
  logic [CH*DB-1:0] m_data = '0;
  logic [CH*LB-1:0] m_lead = '0;
  int               n_done = 0;

  initial forever begin
    bit done, set_o, set_e;
    @(posedge clk_adc or posedge rst_adc);
    if (rst_adc) begin
      m_active = 1'b0; m_k = 0; m_cs = 1'b1; m_valid = 1'b0;
      m_ovr = 1'b0; m_err = 1'b0; m_data = '0; m_lead = '0;
    end else begin
      done = 1'b0; set_o = 1'b0; set_e = 1'b0;
      if (!m_active) begin
        if (start_i || cont_i) begin
          m_active = 1'b1;
          m_k = 0;
          for (int c = 0; c < CH; c++) begin
            m_acc[c]  = '0;
            m_word[c] = use_fixed ? fixed_word[c] : FB'($urandom);
          end
        end
      end else begin
        m_k++;
        if (m_k <= FB)
          for (int c = 0; c < CH; c++) m_acc[c] = (m_acc[c] << 1) | FB'(data_i[c]);
        if (m_k == FB) done = 1'b1;
        if (m_k == FB + GC) m_active = 1'b0;
      end
      if (done) begin
        set_o = m_valid && !ready_i;
        m_valid = 1'b1;
        for (int c = 0; c < CH; c++) begin
          m_data[c*DB +: DB] = m_acc[c][DB-1:0];
          m_lead[c*LB +: LB] = m_acc[c][FB-1:DB];
        end
        n_done++;
      end else if (ready_i) begin
        m_valid = 1'b0;
      end
`ifdef ADC_LEAD_CHECK_EN
      set_e = done && (m_lead != '0);
`endif
      if (set_o) m_ovr = 1'b1; else if (clr_i) m_ovr = 1'b0;
      if (set_e) m_err = 1'b1; else if (clr_i) m_err = 1'b0;
      m_cs = !(m_active && m_k < FB);
    end
  end

  // ADC pin emulation: stream the current frame word MSB-first, noise otherwise
  initial forever begin
    @(negedge clk_adc);
    for (int c = 0; c < CH; c++) begin
      if (m_active && m_k < FB) data_i[c] = m_word[c][FB-1-m_k];
      else                      data_i[c] = 1'($urandom_range(0, 1));
    end
  end

  // Per-cycle compare of every output against the model
  initial forever begin
    @(posedge clk_adc);
    #1;
    if (!rst_adc) begin
      chk("cs_o", 64'(cs_o), 64'(m_cs));
      chk("busy_o", 64'(busy_o), 64'(m_active));
      chk("valid_o", 64'(valid_o), 64'(m_valid));
      chk("data_o", 64'(data_o), 64'(m_data));
      chk("lead_o", 64'(lead_o), 64'(m_lead));
      chk("overrun_o", 64'(overrun_o), 64'(m_ovr));
      chk("err_o", 64'(err_o), 64'(m_err));
    end
  end

  // Pin-level monitor: CS falling times and valid rises
  int cyc = 0;
  int falls [$];
  int vrise = 0;
  bit prev_cs = 1'b1;
  bit prev_v = 1'b0;
  initial forever begin
    @(negedge clk_adc);
    cyc++;
    if (prev_cs && !cs_o) falls.push_back(cyc);
    if (!prev_v && valid_o) vrise++;
    prev_cs = cs_o;
    prev_v = valid_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_adc);
  endtask

  task automatic shot();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 60 && m_active; i++) tick(1);
    if (m_active) chk("wait_idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_done();
    int p;
    int i;
    p = n_done;
    for (i = 0; i < 60 && n_done == p; i++) tick(1);
    if (n_done == p) chk("wait_done_timeout", 64'(1), 64'(0));
  endtask

  task automatic wait_k(input int k);
    int i;
    for (i = 0; i < 60 && !(m_active && m_k == k); i++) tick(1);
    if (!(m_active && m_k == k)) chk("wait_k_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int cnt;
    int i;
    int v0;
    int f0;

    tick(3);
    chk("rst_cs", 64'(cs_o), 64'(1));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ovr", 64'(overrun_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    rst_adc = 1'b0;
    tick(2);

    // Single shot with known frames
    use_fixed = 1'b1;
    fixed_word[0] = 16'h0ABC;
    fixed_word[1] = 16'h0123;
    shot();
    cnt = 0;
    for (i = 0; i < 40 && !valid_o; i++) begin
      if (!cs_o) cnt++;
      tick(1);
    end
    chk("single_valid_seen", 64'(valid_o), 64'(1));
    chk("single_cs_low_edges", 64'(cnt), 64'(16));
    chk("single_data", 64'(data_o), 64'h123ABC);
    chk("single_lead", 64'(lead_o), 64'h00);
    tick(1);
    chk("single_busy_1after", 64'(busy_o), 64'(1));
    tick(1);
    chk("single_busy_2after", 64'(busy_o), 64'(0));
    ready_i = 1'b1; tick(1); ready_i = 1'b0;
    chk("single_consumed", 64'(valid_o), 64'(0));

    // Overrun across two unaccepted frames, then clear
    fixed_word[0] = 16'h0111;
    fixed_word[1] = 16'h0222;
    shot();
    wait_done();
    chk("ovr_first", 64'(overrun_o), 64'(0));
    fixed_word[0] = 16'h0555;
    fixed_word[1] = 16'h0AAA;
    wait_idle();
    shot();
    wait_done();
    chk("ovr_second", 64'(overrun_o), 64'(1));
    chk("ovr_data", 64'(data_o), 64'hAAA555);
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    chk("ovr_cleared", 64'(overrun_o), 64'(0));
    chk("ovr_valid_kept", 64'(valid_o), 64'(1));
    ready_i = 1'b1; tick(1);

    // Continuous mode with ready held high
    wait_idle();
    use_fixed = 1'b0;
    falls.delete();
    cont_i = 1'b1;
    for (i = 0; i < 200 && falls.size() < 5; i++) tick(1);
    chk("cont_falls", 64'(falls.size() >= 5), 64'(1));
    if (falls.size() >= 5)
      for (int j = 0; j < 4; j++) chk("cont_period", 64'(falls[j+1] - falls[j]), 64'(19));
    chk("cont_no_ovr", 64'(overrun_o), 64'(0));
    wait_k(5);
    cont_i = 1'b0;
    v0 = vrise;
    f0 = falls.size();
    tick(60);
    chk("cont_stop_samples", 64'(vrise - v0), 64'(1));
    chk("cont_stop_no_fall", 64'(falls.size() - f0), 64'(0));
    chk("cont_stop_cs", 64'(cs_o), 64'(1));

    // start_i held through frames; accept on a completion edge
    ready_i = 1'b0;
    start_i = 1'b1;
    wait_done();
    wait_k(FB - 1);
    ready_i = 1'b1; tick(1); ready_i = 1'b0;
    chk("same_edge_valid", 64'(valid_o), 64'(1));
    chk("same_edge_no_ovr", 64'(overrun_o), 64'(0));
    if (falls.size() >= 2)
      chk("held_start_period", 64'(falls[$] - falls[$-1]), 64'(19));
    start_i = 1'b0;
    wait_idle();
    ready_i = 1'b1; tick(1); ready_i = 1'b0;

    // Reset mid-frame, then a clean frame
    use_fixed = 1'b1;
    fixed_word[0] = 16'h0F0F;
    fixed_word[1] = 16'h0C3C;
    shot();
    wait_k(7);
    rst_adc = 1'b1;
    #1;
    chk("midrst_cs", 64'(cs_o), 64'(1));
    chk("midrst_valid", 64'(valid_o), 64'(0));
    chk("midrst_data", 64'(data_o), 64'(0));
    chk("midrst_busy", 64'(busy_o), 64'(0));
    tick(1);
    rst_adc = 1'b0;
    tick(1);
    shot();
    wait_done();
    chk("postrst_data", 64'(data_o), 64'hC3CF0F);
    ready_i = 1'b1; tick(1); ready_i = 1'b0;

    // Leading-bit check
    wait_idle();
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    chk("lead_pre_err", 64'(err_o), 64'(0));
    fixed_word[0] = 16'h8ABC;
    fixed_word[1] = 16'h0123;
    shot();
    wait_done();
    chk("lead_bits", 64'(lead_o[LB-1:0]), 64'h8);
    chk("lead_data", 64'(data_o), 64'h123ABC);
`ifdef ADC_LEAD_CHECK_EN
    chk("lead_err_set", 64'(err_o), 64'(1));
    tick(3);
    chk("lead_err_sticky", 64'(err_o), 64'(1));
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    chk("lead_err_clr", 64'(err_o), 64'(0));
`else
    chk("lead_err_off", 64'(err_o), 64'(0));
`endif
    ready_i = 1'b1; tick(1); ready_i = 1'b0;

    // Randomized traffic
    use_fixed = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      start_i = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) cont_i = ~cont_i;
      ready_i = 1'($urandom_range(0, 1));
      clr_i = ($urandom_range(0, 15) == 0);
      tick(1);
    end
    start_i = 1'b0; cont_i = 1'b0; ready_i = 1'b0; clr_i = 1'b0;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_serial_rx_mc.md
Name: adc_serial_rx_mc

Overview:
- Parametrised multi-channel serial ADC frame receiver for SPI-style ADCs that shift MSB-first, such as a dual-channel Pmod with one data line per ADC and a shared CS.
- Owns the shared chip-select, captures one frame per conversion on every channel in parallel, and presents the packed samples with a valid/ready handshake.
- Supports single-shot and continuous conversion modes, a guaranteed CS-high gap, and sticky overrun reporting.
- Sits between the ADC pins and the sample-processing or display logic, all in the clk_adc domain.

Parameters:
- CHANNELS, 2, number of serial data lines sampled in parallel (1..8).
- FRAME_BITS, 16, clocks per conversion frame with CS low (2..32).
- DATA_BITS, 12, LSBs of each frame kept as the sample; must be < FRAME_BITS.
- GAP_CYCLES, 2, minimum extra CS-high cycles after a frame (>=1).

Ports:
- clk_adc  in  1  ADC serial clock; all logic on its rising edge.
- rst_adc  in  1  reset, asynchronous, active-high.
- start_i  in  1  request one conversion; sampled only in IDLE.
- cont_i  in  1  continuous mode: restart automatically from IDLE while high.
- data_i  in  CHANNELS  serial data, bit c = channel c.
- ready_i  in  1  consumer accepts the sample when high with valid_o.
- clr_i  in  1  clears overrun_o and err_o.
- cs_o  out  1  ADC chip-select, active-low.
- data_o  out  CHANNELS*DATA_BITS  channel c at [c*DATA_BITS +: DATA_BITS].
- lead_o  out  CHANNELS*(FRAME_BITS-DATA_BITS)  leading frame bits, channel c at [c*L +: L], L = FRAME_BITS-DATA_BITS.
- valid_o  out  1  a sample is held in data_o/lead_o.
- overrun_o  out  1  sticky: an unaccepted sample was overwritten.
- err_o  out  1  sticky leading-bit error (see Optional Feature).
- busy_o  out  1  high when the state is not IDLE.

Behaviour:
- Reset values (asynchronous):
  - cs_o=1.
  - data_o, lead_o, shift registers and counters = 0.
  - valid_o=0, overrun_o=0, err_o=0, state IDLE.
  - Any partial frame is discarded.
- States:
  - IDLE:
    - Edge with (start_i | cont_i): cs_o<=0, bit counter<=0, go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT:
    - Each edge, every channel's shift register shifts left, taking data_i[c] into the LSB; counter increments.
    - On the edge where counter==FRAME_BITS-1, the last bit is shifted in together with:
      - cs_o<=1.
      - data_o/lead_o <= the complete frames.
      - valid_o<=1.
      - gap counter<=0, go to GAP.
    - cs_o is therefore low for exactly FRAME_BITS edges.
  - GAP:
    - cs_o stays high; gap counter increments.
    - On the edge where gap counter==GAP_CYCLES-1, go to IDLE.
- start_i and cont_i are ignored outside IDLE. There is no queuing.
- Minimum frame period is FRAME_BITS+GAP_CYCLES+1 cycles (19 at defaults).
- Handshake:
  - valid_o clears on an edge with ready_i=1, unless a new frame completes on that same edge, in which case valid_o stays 1 with the new data and no overrun is flagged.
  - data_o and lead_o hold stable while valid_o=1 and no frame completes.
- Overrun:
  - Frame completion while valid_o=1 and ready_i=0: new data overwrites and overrun_o<=1.
  - overrun_o holds until clr_i or reset.
  - If clr_i and a new overrun occur on the same edge, the set wins.
- busy_o is combinational from state.
- cont_i deasserted mid-frame: the current frame completes normally and the block returns to IDLE without restarting.

Optional Feature:
- Macro ADC_LEAD_CHECK_EN.
- Defined: on frame completion, if any lead_o bit of any channel is 1, err_o<=1. err_o is sticky until clr_i or reset, with set winning over clr_i on the same edge.
- Undefined: err_o is tied to 0, with no check logic. lead_o is still driven.

Test Plan:
- Single shot, default parameters:
  - Stimulus: pulse start_i in IDLE; ch0 streams 0x0ABC, ch1 streams 0x0123.
  - Required: cs_o low for exactly 16 edges; valid_o rises on the 16th edge; data_o=24'h123ABC, lead_o=8'h00, busy_o falls 2 edges later.
- Continuous mode:
  - Stimulus: cont_i=1, ready_i=1.
  - Required: cs_o falls every 19 cycles; 4 consecutive frames are captured with no overrun; after cont_i drops mid-frame, exactly one more sample appears and cs_o stays high.
- Overrun:
  - Stimulus: ready_i=0 across two frames, then clr_i for 1 cycle.
  - Required: overrun_o=1 at the second completion; data_o holds the second frame; clr_i clears overrun_o while valid_o stays 1.
- Reset mid-frame:
  - Stimulus: assert rst_adc after 7 bits.
  - Required: cs_o=1, valid_o=0 and data_o=0 immediately, without waiting for a clock; the next start_i yields a clean full frame.
- Lead check (ADC_LEAD_CHECK_EN defined):
  - Stimulus: ch0 frame 0x8ABC.
  - Required: lead_o[3:0]=4'h8, err_o=1 and sticky; with the macro undefined, err_o stays 0.
- Start during SHIFT and same-edge accept:
  - Stimulus: start_i held high throughout a frame, then ready_i=1 on a completion edge.
  - Required: exactly one frame per IDLE visit; no overrun; valid_o stays 1 with the new data.
